// File: rtl/arm_mem_pkg.sv
// Shared definitions for the MEM-stage SRAM controller.
//   mem_state_e         : controller FSM encoding
//   DEFAULT_BASE_ADDR   : byte address of data-memory word 0
//   DEFAULT_WAIT_CYCLES : cycles each 16-bit half-access stays on the bus
//   DEFAULT_SRAM_AW     : SRAM halfword address width
package arm_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } mem_state_e;

  localparam int unsigned DEFAULT_BASE_ADDR   = 1024;
  localparam int unsigned DEFAULT_WAIT_CYCLES = 2;
  localparam int unsigned DEFAULT_SRAM_AW     = 18;

endpackage : arm_mem_pkg

// File: rtl/sram_model.sv
// Behavioural asynchronous SRAM, 2^AW x 16.
// Reads are combinational while oe_n is low; a write commits on the rising
// edge of we_n using the address and data present at that edge.
// Ports:
//   addr  : halfword address
//   dq_wr : data driven towards the SRAM
//   we_n  : write enable, active-low
//   oe_n  : output enable, active-low
//   dq_rd : data driven by the SRAM (0 while oe_n is high)
module sram_model #(
  parameter int unsigned AW = 18
) (
  input  logic [AW-1:0] addr,
  input  logic [15:0]   dq_wr,
  input  logic          we_n,
  input  logic          oe_n,
  output logic [15:0]   dq_rd
);

  logic [15:0] mem [0:(1<<AW)-1];

  always_ff @(posedge we_n) begin
    mem[addr] <= dq_wr;
  end

  assign dq_rd = oe_n ? 16'h0000 : mem[addr];

endmodule : sram_model

// File: rtl/sram_controller.sv
// MEM-stage responder: turns one 32-bit load/store from the EXE/MEM pipeline
// register into two 16-bit accesses on an external asynchronous SRAM, and
// drives ready (sram_ready) to stall or advance the pipeline.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   rd_en, wr_en        : request (wr_en wins when both are high)
//   address, write_data : byte address and store data, held stable by the pipeline
//   read_data           : registered load result, valid in DONE
//   ready               : high when the pipeline may advance
//   sram_*              : SRAM bus (all registered, glitch-free)
//
// state | meaning
// IDLE  | waiting for a request; ready=1 only with no request pending
// LO    | low halfword access (address {word,0}), WAIT_CYCLES cycles
// HI    | high halfword access (address {word,1}), WAIT_CYCLES cycles
// DONE  | one cycle, ready=1, read_data valid
module sram_controller
  import arm_mem_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
  parameter int unsigned SRAM_AW     = DEFAULT_SRAM_AW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  localparam int unsigned      CNT_W   = $clog2(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_CYCLES - 1);

  mem_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_wr_q, is_wr_d;
  logic [31:0]        read_data_q, read_data_d;
  logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
  logic [15:0]        dq_out_q, dq_out_d;
  logic               dq_oe_q, dq_oe_d;
  logic               we_n_q, we_n_d;
  logic               oe_n_q, oe_n_d;

  logic [31:0]        offset;
  logic [SRAM_AW-2:0] word;
  logic               last_cycle;
  logic               unused_addr_bits;

  // Word index relative to the data-memory base; byte lane bits are dropped
  // and anything above the SRAM range wraps.
  assign offset           = address - 32'(BASE_ADDR);
  assign word             = offset[SRAM_AW:2];
  assign unused_addr_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

  assign last_cycle = (cnt_q == CNT_MAX);

  // Next-state, counter and read capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_wr_d     = is_wr_q;
    read_data_d = read_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rd_en || wr_en) begin
          state_d = ST_LO;
          cnt_d   = '0;
          is_wr_d = wr_en;
        end
      end
      ST_LO: begin
        if (last_cycle) begin
          state_d = ST_HI;
          cnt_d   = '0;
          if (!is_wr_q) read_data_d[15:0] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HI: begin
        if (last_cycle) begin
          state_d = ST_DONE;
          if (!is_wr_q) read_data_d[31:16] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bus outputs are decoded from the upcoming state so they can be registered.
  // we_n rises on the final cycle of each phase, committing the write while
  // address and data are still held.
  always_comb begin
    sram_addr_d = '0;
    dq_out_d    = 16'h0000;
    dq_oe_d     = 1'b0;
    we_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    if (state_d == ST_LO || state_d == ST_HI) begin
      sram_addr_d = {word, (state_d == ST_HI)};
      if (is_wr_d) begin
        dq_oe_d  = 1'b1;
        dq_out_d = (state_d == ST_HI) ? write_data[31:16] : write_data[15:0];
        we_n_d   = (cnt_d == CNT_MAX);
      end else begin
        oe_n_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      is_wr_q     <= 1'b0;
      read_data_q <= 32'h0;
      sram_addr_q <= '0;
      dq_out_q    <= 16'h0000;
      dq_oe_q     <= 1'b0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_wr_q     <= is_wr_d;
      read_data_q <= read_data_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
    end
  end

  // A fresh request must not see ready in its first IDLE cycle.
  assign ready = (state_q == ST_DONE) || (state_q == ST_IDLE && !rd_en && !wr_en);

  assign read_data   = read_data_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_we_n   = we_n_q;
  assign sram_oe_n   = oe_n_q;

endmodule : sram_controller
